// File: rtl/pp_accum_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pp_accum_pkg
//  Description : Shared widths and the Booth term-alignment helper used by
//                the partial-product accumulate pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package pp_accum_pkg;

   localparam int PP_W   = 9;
   localparam int NUM_PP = 4;
   localparam int PROD_W = 16;
   localparam int ACC_W  = 24;

   // Sign-extend one partial product, add its negate-correction bit and
   // weight it by 4^idx (radix-4 Booth digit position). Arithmetic wraps
   // at PROD_W bits.
   function automatic logic [PROD_W-1:0] term_align(
      input logic [PP_W-1:0] pp,
      input logic            sign,
      input int              idx
   );
      logic [PROD_W-1:0] t;
      t = {{(PROD_W-PP_W){pp[PP_W-1]}}, pp} + {{(PROD_W-1){1'b0}}, sign};
      return t << (2 * idx);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pp_term_align.sv
`default_nettype none
// ============================================================================
//  Module      : pp_term_align
//  Description : Combinational former of one weighted Booth term.
//  Revision    : 1.0 - initial release
// ============================================================================
module pp_term_align
   import pp_accum_pkg::*;
#(
   parameter int IDX = 0
)(
   input  logic [PP_W-1:0]   pp,
   input  logic              sign,
   output logic [PROD_W-1:0] term
);

   // Weighted term for digit position IDX
   assign term = term_align(pp, sign, IDX);

endmodule
`default_nettype wire

// File: rtl/pp_accum_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : pp_accum_pipe
//  Description : Two-stage valid/ready pipeline that sums four Booth partial
//                products into a 16-bit product and keeps a 24-bit signed
//                running accumulation with a sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module pp_accum_pipe
   import pp_accum_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PP_W-1:0]   pp0,
   input  logic [PP_W-1:0]   pp1,
   input  logic [PP_W-1:0]   pp2,
   input  logic [PP_W-1:0]   pp3,
   input  logic              sign0,
   input  logic              sign1,
   input  logic              sign2,
   input  logic              sign3,
   input  logic              acc_clr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] product,
   output logic [ACC_W-1:0]  acc,
   output logic              acc_ovf
);

   logic [PP_W-1:0]   pp_arr   [NUM_PP];
   logic              sign_arr [NUM_PP];
   logic [PROD_W-1:0] term_arr [NUM_PP];

   // Stage S1 state
   logic              s1_valid;
   logic [PROD_W-1:0] s01;
   logic [PROD_W-1:0] s23;
   logic              s1_clr;

   // Stage S2 state (product/acc/acc_ovf are the S2 registers themselves)
   logic              s2_valid;

   // Handshake and datapath nets
   logic              s2_adv;
   logic              s1_load;
   logic              s2_load;
   logic [PROD_W-1:0] prod_sum;
   logic [ACC_W-1:0]  prod_ext;
   logic [ACC_W-1:0]  acc_base;
   logic [ACC_W-1:0]  acc_sum;
   logic              ovf_now;

   assign pp_arr   = '{pp0, pp1, pp2, pp3};
   assign sign_arr = '{sign0, sign1, sign2, sign3};

   generate
      for (genvar g = 0; g < NUM_PP; g++) begin : g_term
         pp_term_align #(
            .IDX (g)
         ) u_align (
            .pp   (pp_arr[g]),
            .sign (sign_arr[g]),
            .term (term_arr[g])
         );
      end
   endgenerate

   // Ready chain: S2 frees when empty or draining; S1 frees when empty or
   // moving into S2. No dependence on in_valid.
   assign s2_adv    = !s2_valid || out_ready;
   assign in_ready  = !s1_valid || s2_adv;
   assign s1_load   = in_valid && in_ready;
   assign s2_load   = s1_valid && s2_adv;
   assign out_valid = s2_valid;

   // Final product sum and signed accumulate with overflow detection; an
   // acc_clr beat starts from zero rather than the current total.
   always_comb begin
      prod_sum = s01 + s23;
      prod_ext = {{(ACC_W-PROD_W){prod_sum[PROD_W-1]}}, prod_sum};
      acc_base = s1_clr ? '0 : acc;
      acc_sum  = acc_base + prod_ext;
      ovf_now  = (acc_base[ACC_W-1] == prod_ext[ACC_W-1]) &&
                 (acc_sum[ACC_W-1]  != acc_base[ACC_W-1]);
   end

   // Stage S1: capture pairwise term sums and the clear flag on accept
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s01      <= '0;
         s23      <= '0;
         s1_clr   <= 1'b0;
      end else if (s1_load) begin
         s1_valid <= 1'b1;
         s01      <= term_arr[0] + term_arr[1];
         s23      <= term_arr[2] + term_arr[3];
         s1_clr   <= acc_clr;
      end else if (s2_adv) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage S2: register product, accumulation and sticky overflow on load;
   // outputs hold while stalled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s2_valid <= 1'b0;
         product  <= '0;
         acc      <= '0;
         acc_ovf  <= 1'b0;
      end else if (s2_load) begin
         s2_valid <= 1'b1;
         product  <= prod_sum;
         acc      <= acc_sum;
         acc_ovf  <= s1_clr ? ovf_now : (acc_ovf | ovf_now);
      end else if (out_ready) begin
         s2_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pp_accum_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pp_accum_pipe
//  Description : Self-checking bench for pp_accum_pipe with a reference
//                model of product/accumulation computed in plain integers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pp_accum_pipe;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [8:0]  pp0 = '0, pp1 = '0, pp2 = '0, pp3 = '0;
   logic        sign0 = 1'b0, sign1 = 1'b0, sign2 = 1'b0, sign3 = 1'b0;
   logic        acc_clr = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] product;
   logic [23:0] acc;
   logic        acc_ovf;

   typedef struct {
      logic [15:0] prod;
      logic [23:0] acc;
      logic        ovf;
   } exp_t;

   exp_t        exp_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          accepts = 0;
   int          emits   = 0;
   int          m_acc   = 0;
   logic        m_ovf   = 1'b0;
   logic        prev_stall = 1'b0;
   logic [15:0] held_prod;
   logic [23:0] held_acc;
   logic        held_ovf;
   logic [15:0] last_prod;
   logic [23:0] last_acc;
   logic        last_ovf;
   int          base_acc;
   int          base_emit;

   always #5 clk = ~clk;

   pp_accum_pipe dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .pp0       (pp0),
      .pp1       (pp1),
      .pp2       (pp2),
      .pp3       (pp3),
      .sign0     (sign0),
      .sign1     (sign1),
      .sign2     (sign2),
      .sign3     (sign3),
      .acc_clr   (acc_clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .acc       (acc),
      .acc_ovf   (acc_ovf)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: product = sum of (signed pp + sign) * 4^n, acc as a signed
   // 24-bit running total, overflow judged on the exact integer sum.
   task automatic push_model();
      logic [8:0]  p[4];
      logic        s[4];
      int          t;
      int          v;
      longint      a;
      logic [15:0] pr;
      logic [23:0] w;
      logic        ovf;
      exp_t        e;
      p[0] = pp0; p[1] = pp1; p[2] = pp2; p[3] = pp3;
      s[0] = sign0; s[1] = sign1; s[2] = sign2; s[3] = sign3;
      t = 0;
      for (int n = 0; n < 4; n++) begin
         v = int'($signed(p[n])) + (s[n] ? 1 : 0);
         t = t + v * (1 << (2 * n));
      end
      pr = t[15:0];
      if (acc_clr) m_acc = 0;
      a   = longint'(m_acc) + longint'($signed(pr));
      ovf = (a > 8388607) || (a < -8388608);
      w   = a[23:0];
      m_acc = int'($signed(w));
      m_ovf = acc_clr ? ovf : (m_ovf | ovf);
      e.prod = pr;
      e.acc  = w;
      e.ovf  = m_ovf;
      exp_q.push_back(e);
   endtask

   // One clock: observe handshakes mid-cycle, then advance past the edge
   task automatic step();
      exp_t e;
      @(negedge clk);
      if (prev_stall) begin
         check("hold_product", product, held_prod);
         check("hold_acc", acc, held_acc);
         check("hold_ovf", acc_ovf, held_ovf);
      end
      prev_stall = out_valid && !out_ready;
      held_prod  = product;
      held_acc   = acc;
      held_ovf   = acc_ovf;
      if (out_valid && out_ready) begin
         emits++;
         last_prod = product;
         last_acc  = acc;
         last_ovf  = acc_ovf;
         if (exp_q.size() == 0) begin
            check("unexpected_emit", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("product", product, e.prod);
            check("acc", acc, e.acc);
            check("acc_ovf", acc_ovf, e.ovf);
         end
      end
      if (in_valid && in_ready) begin
         accepts++;
         push_model();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rand_beat(input int clr_pct);
      pp0 = 9'($urandom); pp1 = 9'($urandom); pp2 = 9'($urandom); pp3 = 9'($urandom);
      sign0 = 1'($urandom); sign1 = 1'($urandom); sign2 = 1'($urandom); sign3 = 1'($urandom);
      acc_clr = ($urandom_range(0, 99) < clr_pct);
   endtask

   task automatic set_beat(input logic [8:0] a, b, c, d, input logic s0, input logic clr);
      pp0 = a; pp1 = b; pp2 = c; pp3 = d;
      sign0 = s0; sign1 = 1'b0; sign2 = 1'b0; sign3 = 1'b0;
      acc_clr = clr;
   endtask

   task automatic drain();
      int k;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      k = 0;
      while ((exp_q.size() != 0 || out_valid) && k < 40) begin
         step();
         k++;
      end
      check("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_product", product, 0);
      check("rst_acc", acc, 0);
      check("rst_ovf", acc_ovf, 0);
      reset_n = 1'b1;
      #1;
      check("rst_in_ready", in_ready, 1);

      // Single beat and latency
      out_ready = 1'b1;
      set_beat(9'h00A, 9'h005, 9'h000, 9'h000, 1'b0, 1'b1);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("lat_edge_n", out_valid, 0);
      @(negedge clk);
      check("lat_edge_n1", out_valid, 0);
      @(posedge clk);
      #1;
      check("lat_edge_n2", out_valid, 1);
      check("single_product", product, 16'h001E);
      check("single_acc", acc, 24'h00001E);
      drain();

      // Negation
      set_beat(9'h1FC, 9'h000, 9'h000, 9'h000, 1'b1, 1'b1);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      drain();
      check("neg_product", last_prod, 16'hFFFD);
      check("neg_acc", last_acc, 24'hFFFFFD);

      // Stall: three offered beats, two accepted, then release
      out_ready = 1'b0;
      base_acc  = accepts;
      base_emit = emits;
      in_valid  = 1'b1;
      rand_beat(30); step();
      rand_beat(30); step();
      check("stall_in_ready", in_ready, 0);
      rand_beat(30); step();
      check("stall_accepts", accepts - base_acc, 2);
      check("stall_in_ready2", in_ready, 0);
      out_ready = 1'b1;
      for (int k = 0; k < 10 && accepts - base_acc < 3; k++) step();
      drain();
      check("stall_accepts_all", accepts - base_acc, 3);
      check("stall_emits", emits - base_emit, 3);

      // Overflow run: 387 beats reach just under the positive limit
      base_acc = accepts;
      in_valid = 1'b1;
      for (int k = 0; k < 387; k++) begin
         set_beat(9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF, 1'b0, k == 0);
         step();
      end
      check("ovf_throughput", accepts - base_acc, 387);
      drain();
      check("ovf387_product", last_prod, 16'h54AB);
      check("ovf387_acc", last_acc, 24'h7FFE81);
      check("ovf387_flag", last_ovf, 0);
      set_beat(9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF, 1'b0, 1'b0);
      in_valid = 1'b1;
      step();
      drain();
      check("ovf388_acc", last_acc, 24'h80532C);
      check("ovf388_flag", last_ovf, 1);
      set_beat(9'h001, 9'h000, 9'h000, 9'h000, 1'b0, 1'b1);
      in_valid = 1'b1;
      step();
      drain();
      check("ovf_clr_flag", last_ovf, 0);
      check("ovf_clr_acc", last_acc, 24'h000001);

      // Randomized traffic with random backpressure
      for (int k = 0; k < 600; k++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         rand_beat(10);
         step();
      end
      drain();

      // Mid-run reset with two beats in flight
      out_ready = 1'b0;
      base_acc  = accepts;
      in_valid  = 1'b1;
      rand_beat(0); step();
      rand_beat(0); step();
      check("mrst_accepts", accepts - base_acc, 2);
      in_valid = 1'b0;
      reset_n  = 1'b0;
      #1;
      check("mrst_out_valid", out_valid, 0);
      check("mrst_acc", acc, 0);
      check("mrst_ovf", acc_ovf, 0);
      check("mrst_product", product, 0);
      exp_q.delete();
      m_acc = 0;
      m_ovf = 1'b0;
      prev_stall = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      #1;
      check("mrst_in_ready", in_ready, 1);
      base_emit = emits;
      out_ready = 1'b1;
      repeat (5) step();
      check("mrst_no_emit", emits - base_emit, 0);

      // Short random tail after reset to confirm a clean restart
      for (int k = 0; k < 100; k++) begin
         in_valid  = ($urandom_range(0, 1) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         rand_beat(10);
         step();
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
